// File: rtl/risc_prog_loader.sv
// risc_prog_loader
//   Writes a program into the byte-wide instruction memory of the RISC core.
//   Each accepted set of instruction fields is packed into a 32-bit word
//   ([4:0]=rs2, [9:5]=rs1, [14:10]=rd, [17:15]=opcode, upper bits zero) and
//   written little-endian, one byte per cycle, at consecutive word addresses.
//   The core is held in reset (o_cpu_hold) until the last word has been written
//   or the memory is full.
//
// Optional feature macro: RISC_LOADER_VERIFY_EN
//   When defined, four readback cycles follow each word and compare
//   i_mem_rdata against the byte just written. Any mismatch sets o_verify_err.
//   When undefined, i_mem_rdata is ignored and o_verify_err is tied low.
//
// Ports
//   i_clock, i_rst         : clock, synchronous active-high reset
//   i_in_valid/o_in_ready  : instruction field handshake
//   i_in_opcode/rd/rs1/rs2 : instruction fields; i_in_last marks the final word
//   o_mem_we/addr/wdata    : byte write port
//   i_mem_rdata            : asynchronous read data (used for verify only)
//   o_cpu_hold             : 1 keeps the core in reset
//   o_load_done            : sticky, program fully written
//   o_mem_full             : sticky, memory filled before the last word was seen
//   o_word_count           : number of words written
//   o_verify_err           : sticky readback mismatch
module risc_prog_loader #(
  parameter int ADDR_W     = 6,
  parameter int MEM_BYTES  = 64,
  parameter int START_ADDR = 0
) (
  input  logic              i_clock,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [2:0]        i_in_opcode,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_rs1,
  input  logic [4:0]        i_in_rs2,
  input  logic              i_in_last,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_mem_full,
  output logic [ADDR_W-2:0] o_word_count,
  output logic              o_verify_err
);

  localparam int MEM_WORDS = MEM_BYTES / 4;
  localparam logic [ADDR_W-2:0] LAST_COUNT = (ADDR_W-1)'(MEM_WORDS);
  localparam logic [ADDR_W-1:0] START      = ADDR_W'(START_ADDR);

  typedef enum logic [3:0] {
    S_IDLE, S_W0, S_W1, S_W2, S_W3, S_R0, S_R1, S_R2, S_R3, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_word;
  logic              r_last;
  logic              r_armed;     // keeps in_ready low for one cycle after reset
  logic [ADDR_W-2:0] r_word_count;
  logic              r_mem_full;

  logic              w_in_ready;
  logic              w_we;
  logic              w_rd_chk;
  logic              w_word_end;  // final cycle of a word: advance base/count
  logic [1:0]        w_idx;
  logic [7:0]        w_byte;
  logic [7:0]        w_wdata;
  logic [ADDR_W-2:0] w_cnt_inc;
  logic [31:0]       w_packed;

  assign w_packed  = {14'd0, i_in_opcode, i_in_rd, i_in_rs1, i_in_rs2};
  assign w_byte    = r_word[{w_idx, 3'b000} +: 8];
  assign w_cnt_inc = r_word_count + 1'b1;

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_we       = 1'b0;
    w_rd_chk   = 1'b0;
    w_word_end = 1'b0;
    w_idx      = 2'd0;
    w_wdata    = 8'h00;
    case (r_state)
      S_IDLE: begin
        w_in_ready = r_armed;
        if (i_in_valid && r_armed) w_next = S_W0;
      end
      S_W0: begin w_we = 1'b1; w_idx = 2'd0; w_next = S_W1; end
      S_W1: begin w_we = 1'b1; w_idx = 2'd1; w_next = S_W2; end
      S_W2: begin w_we = 1'b1; w_idx = 2'd2; w_next = S_W3; end
      S_W3: begin
        w_we  = 1'b1;
        w_idx = 2'd3;
`ifdef RISC_LOADER_VERIFY_EN
        w_next = S_R0;
`else
        w_word_end = 1'b1;
`endif
      end
`ifdef RISC_LOADER_VERIFY_EN
      S_R0: begin w_rd_chk = 1'b1; w_idx = 2'd0; w_next = S_R1; end
      S_R1: begin w_rd_chk = 1'b1; w_idx = 2'd1; w_next = S_R2; end
      S_R2: begin w_rd_chk = 1'b1; w_idx = 2'd2; w_next = S_R3; end
      S_R3: begin w_rd_chk = 1'b1; w_idx = 2'd3; w_word_end = 1'b1; end
`endif
      S_DONE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (w_we) w_wdata = w_byte;
    // Stop on the tagged last word or once the final word slot is used.
    if (w_word_end) w_next = (r_last || w_cnt_inc == LAST_COUNT) ? S_DONE : S_IDLE;
  end

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_base       <= START;
      r_word       <= 32'd0;
      r_last       <= 1'b0;
      r_armed      <= 1'b0;
      r_word_count <= '0;
      r_mem_full   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
      if (r_state == S_IDLE && i_in_valid && r_armed) begin
        r_word <= w_packed;
        r_last <= i_in_last;
      end
      if (w_word_end) begin
        r_base       <= r_base + ADDR_W'(4);
        r_word_count <= w_cnt_inc;
        if (!r_last && w_cnt_inc == LAST_COUNT) r_mem_full <= 1'b1;
      end
    end
  end

`ifdef RISC_LOADER_VERIFY_EN
  logic r_verify_err;
  always_ff @(posedge i_clock) begin
    if (i_rst)                                  r_verify_err <= 1'b0;
    else if (w_rd_chk && i_mem_rdata != w_byte) r_verify_err <= 1'b1;
  end
  assign o_verify_err = r_verify_err;
`else
  logic w_unused_verify;
  assign w_unused_verify = ^{i_mem_rdata, w_rd_chk};
  assign o_verify_err    = 1'b0;
`endif

  assign o_in_ready   = w_in_ready;
  assign o_mem_we     = w_we;
  assign o_mem_addr   = r_base + ADDR_W'(w_idx);
  assign o_mem_wdata  = w_wdata;
  assign o_cpu_hold   = (r_state != S_DONE);
  assign o_load_done  = (r_state == S_DONE);
  assign o_mem_full   = r_mem_full;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_risc_prog_loader.sv
module tb_risc_prog_loader;

`ifdef RISC_LOADER_VERIFY_EN
  localparam int SPACING = 9;
`else
  localparam int SPACING = 5;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_last;
  logic [2:0] in_opcode;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic       mem_we, cpu_hold, load_done, mem_full, verify_err;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [4:0] word_count;

  logic [7:0] mem [64];
  logic       corrupt1;

  typedef struct packed { logic [5:0] addr; logic [7:0] data; } wr_t;
  wr_t        sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [5:0] exp_base;

  always #5 clk = ~clk;

  assign mem_rdata = (corrupt1 && mem_addr == 6'd1) ? 8'h8D : mem[mem_addr];

  risc_prog_loader #(.ADDR_W(6), .MEM_BYTES(64), .START_ADDR(0)) dut (
    .i_clock(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_opcode(in_opcode), .i_in_rd(in_rd), .i_in_rs1(in_rs1), .i_in_rs2(in_rs2),
    .i_in_last(in_last), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_cpu_hold(cpu_hold),
    .o_load_done(load_done), .o_mem_full(mem_full), .o_word_count(word_count),
    .o_verify_err(verify_err)
  );

  // Advance to the next negedge; any write on the bus is popped from the
  // scoreboard and applied to the memory model.
  task automatic cycle();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (mem_we === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%02h (no write expected)", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write addr=%0d data=%02h expected addr=%0d data=%02h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic send_word(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic last, output int acc_cyc);
    logic [31:0] w;
    bit done;
    w = {14'd0, op, rd, rs1, rs2};
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_last = last;
    in_valid = 1'b1;
    done = 0;
    acc_cyc = -1;
    for (int t = 0; t < 40 && !done; t++) begin
      if (in_ready === 1'b1) begin
        for (int k = 0; k < 4; k++) sb.push_back('{addr: exp_base + 6'(k), data: w[8*k +: 8]});
        exp_base = exp_base + 6'd4;
        acc_cyc = cyc;
        done = 1;
      end
      cycle();
    end
    in_valid = 1'b0;
    if (!done) begin
      errors++; checks++;
      $display("FAIL accept_timeout in_ready never asserted within 40 cycles");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; corrupt1 = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    sb.delete();
    exp_base = 6'd0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(); cycle();
    checks++; if (cpu_hold !== 1'b1)   begin errors++; $display("FAIL reset_cpu_hold got %b want 1", cpu_hold); end
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (load_done !== 1'b0)  begin errors++; $display("FAIL reset_load_done got %b want 0", load_done); end
    checks++; if (mem_full !== 1'b0)   begin errors++; $display("FAIL reset_mem_full got %b want 0", mem_full); end
    checks++; if (word_count !== 5'd0) begin errors++; $display("FAIL reset_word_count got %0d want 0", word_count); end
    checks++; if (mem_addr !== 6'd0 || mem_wdata !== 8'h00)
      begin errors++; $display("FAIL reset_bus addr=%0d data=%02h want 0/00", mem_addr, mem_wdata); end
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL reset_verify_err got %b want 0", verify_err); end
    rst = 1'b0;
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL release_in_ready_early got %b want 0", in_ready); end
    cycle();
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    sb.delete();
    exp_base = 6'd0;
  endtask

  task automatic test_two_words();
    int a;
    logic [7:0] exp8 [8];
    exp8 = '{8'h41, 8'h8C, 8'h00, 8'h00, 8'hA3, 8'h18, 8'h01, 8'h00};
    send_word(3'd1, 5'd3, 5'd2, 5'd1, 1'b0, a);
    repeat (SPACING-1) cycle();
    checks++; if (word_count !== 5'd1) begin errors++; $display("FAIL w1_word_count got %0d want 1", word_count); end
    checks++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0)
      begin errors++; $display("FAIL w1_status ready=%b hold=%b done=%b want 1/1/0", in_ready, cpu_hold, load_done); end
    send_word(3'd2, 5'd6, 5'd5, 5'd3, 1'b1, a);
    repeat (SPACING-1) cycle();
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0)
      begin errors++; $display("FAIL w2_done done=%b hold=%b want 1/0", load_done, cpu_hold); end
    checks++; if (mem_full !== 1'b0 || word_count !== 5'd2)
      begin errors++; $display("FAIL w2_count full=%b count=%0d want 0/2", mem_full, word_count); end
    // Inputs must be ignored once loading is done.
    in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %b want 0", in_ready); end
      cycle();
    end
    in_valid = 1'b0;
    checks++; if (word_count !== 5'd2 || load_done !== 1'b1)
      begin errors++; $display("FAIL done_hold count=%0d done=%b want 2/1", word_count, load_done); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem[i] !== exp8[i]) begin errors++; $display("FAIL mem_byte addr=%0d got %02h want %02h", i, mem[i], exp8[i]); end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL pending_writes got %0d want 0", sb.size()); end
  endtask

  task automatic test_fill(input bit last_on_final);
    int a, prev;
    do_reset();
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      send_word(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), last_on_final && (i == 15), a);
      if (i > 0) begin
        checks++; if (a - prev != SPACING) begin errors++; $display("FAIL spacing word=%0d got %0d want %0d", i, a - prev, SPACING); end
      end
      prev = a;
    end
    repeat (SPACING-1) cycle();
    checks++; if (load_done !== 1'b1 || word_count !== 5'd16)
      begin errors++; $display("FAIL fill_done done=%b count=%0d want 1/16", load_done, word_count); end
    checks++; if (mem_full !== !last_on_final)
      begin errors++; $display("FAIL fill_mem_full got %b want %b", mem_full, !last_on_final); end
    in_valid = 1'b1;
    repeat (4) cycle();
    in_valid = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fill_pending got %0d want 0", sb.size()); end
  endtask

  task automatic test_mid_reset();
    int a;
    do_reset();
    send_word(3'd1, 5'd3, 5'd2, 5'd1, 1'b0, a);
    cycle(); cycle();   // now sitting in W2
    rst = 1'b1;
    cycle();
    checks++; if (mem_we !== 1'b0 || word_count !== 5'd0 || cpu_hold !== 1'b1)
      begin errors++; $display("FAIL abort we=%b count=%0d hold=%b want 0/0/1", mem_we, word_count, cpu_hold); end
    checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL abort_addr got %0d want 0", mem_addr); end
    sb.delete();
    exp_base = 6'd0;
    rst = 1'b0;
    cycle();
    send_word(3'd2, 5'd6, 5'd5, 5'd3, 1'b1, a);
    repeat (SPACING-1) cycle();
    checks++; if (load_done !== 1'b1 || word_count !== 5'd1 || mem[0] !== 8'hA3)
      begin errors++; $display("FAIL reload done=%b count=%0d mem0=%02h want 1/1/A3", load_done, word_count, mem[0]); end
  endtask

  task automatic test_verify();
    int a;
    do_reset();
    corrupt1 = 1'b1;
    send_word(3'd1, 5'd3, 5'd2, 5'd1, 1'b1, a);
`ifdef RISC_LOADER_VERIFY_EN
    repeat (4) cycle();  // R0
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL verify_early got %b want 0", verify_err); end
    repeat (2) cycle();  // after R1
    checks++; if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_err got %b want 1", verify_err); end
    repeat (2) cycle();
`else
    repeat (SPACING-1) cycle();
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL verify_tied got %b want 0", verify_err); end
`endif
    checks++; if (load_done !== 1'b1 || word_count !== 5'd1)
      begin errors++; $display("FAIL verify_done done=%b count=%0d want 1/1", load_done, word_count); end
    corrupt1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; corrupt1 = 1'b0;
    in_opcode = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    exp_base = 6'd0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_two_words();
    test_fill(1'b0);
    test_fill(1'b1);
    test_mid_reset();
    test_verify();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
